// File: rtl/mul_pkg.sv
// Shared encodings and helpers for the multiplier result packer.
// Product flags and beat-0 word selection live here so the top stays FSM-only.
package mul_pkg;

    typedef enum logic [1:0] {
        MODE_LO   = 2'b00,
        MODE_HI   = 2'b01,
        MODE_BOTH = 2'b10,
        MODE_SAT  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2
    } state_e;

    localparam logic [31:0] SAT_POS = 32'h7FFF_FFFF;
    localparam logic [31:0] SAT_NEG = 32'h8000_0000;

    typedef struct packed {
        logic ovf;
        logic zero;
        logic neg;
    } flags_t;

    // Fits in 32-bit signed only if bits 63..31 are a pure sign extension.
    function automatic logic prod_ovf(input logic [63:0] p);
        return !((&p[63:31]) || !(|p[63:31]));
    endfunction

    function automatic flags_t prod_flags(input logic [63:0] p);
        flags_t f;
        f.ovf  = prod_ovf(p);
        f.zero = (p == 64'd0);
        f.neg  = p[63];
        return f;
    endfunction

    function automatic logic [31:0] beat0_data(input logic [63:0] p, input mode_e m,
                                               input logic ovf);
        logic [31:0] d;
        case (m)
            MODE_HI:  d = p[63:32];
            MODE_SAT: d = ovf ? (p[63] ? SAT_NEG : SAT_POS) : p[31:0];
            default:  d = p[31:0];
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mul_result_fifo.sv
// Small circular FIFO holding {tag, mode, product} entries ahead of the output stage.
// rdy is registered from the next-state count so it never depends on the consumer.
module mul_result_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 70
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       rdy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PONE     = AW'(1);
    localparam logic [CW-1:0] CONE     = CW'(1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          do_push, do_pop;

    assign do_push = push && (cnt != FULL_CNT);
    assign do_pop  = pop && (cnt != '0);
    assign dout    = mem[rptr];
    assign count   = cnt;

    always_comb begin
        cnt_nxt = cnt;
        if (do_push && !do_pop)
            cnt_nxt = cnt + CONE;
        else if (!do_push && do_pop)
            cnt_nxt = cnt - CONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            rdy  <= 1'b0;
        end else begin
            if (do_push) wptr <= wptr + PONE;
            if (do_pop)  rptr <= rptr + PONE;
            cnt <= cnt_nxt;
            rdy <= (cnt_nxt != FULL_CNT);
        end
    end

    // Storage needs no reset: pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

endmodule

// File: rtl/mul_result_packer.sv
// Returns buffered 64-bit signed products to the 32-bit result bus as one or two beats.
// Output stage is fully registered; flags, mode and tag are latched when an entry is popped.
module mul_result_packer
    import mul_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_product,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_last,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_neg,
    output logic [TAG_W-1:0] out_tag
);
    localparam int EW = 64 + 2 + TAG_W;

    logic [EW-1:0]          fifo_dout;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   fifo_empty;
    logic [63:0]            h_prod;
    mode_e                  h_mode;
    logic [TAG_W-1:0]       h_tag;
    flags_t                 h_flags;

    state_e      state, state_nxt;
    mode_e       cur_mode;
    logic [31:0] hi_word;
    logic        load, to_hi;

    mul_result_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_valid && in_ready),
        .din   ({in_tag, in_mode, in_product}),
        .pop   (load),
        .dout  (fifo_dout),
        .count (fifo_count),
        .rdy   (in_ready)
    );

    assign fifo_empty = (fifo_count == '0);
    assign h_prod     = fifo_dout[63:0];
    assign h_mode     = mode_e'(fifo_dout[65:64]);
    assign h_tag      = fifo_dout[EW-1:66];
    assign h_flags    = prod_flags(h_prod);
    assign out_valid  = (state != ST_EMPTY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_EMPTY;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        to_hi     = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (!fifo_empty) begin
                    load      = 1'b1;
                    state_nxt = ST_BEAT0;
                end
            end
            ST_BEAT0: begin
                if (out_ready) begin
                    if (cur_mode == MODE_BOTH) begin
                        to_hi     = 1'b1;
                        state_nxt = ST_BEAT1;
                    end else if (!fifo_empty) begin
                        load      = 1'b1;
                    end else begin
                        state_nxt = ST_EMPTY;
                    end
                end
            end
            ST_BEAT1: begin
                if (out_ready) begin
                    if (!fifo_empty) begin
                        load      = 1'b1;
                        state_nxt = ST_BEAT0;
                    end else begin
                        state_nxt = ST_EMPTY;
                    end
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    // The high word is parked at pop so beat 1 needs no access to the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_mode <= MODE_LO;
            hi_word  <= '0;
            out_data <= '0;
            out_last <= 1'b0;
            out_ovf  <= 1'b0;
            out_zero <= 1'b0;
            out_neg  <= 1'b0;
            out_tag  <= '0;
        end else if (load) begin
            cur_mode <= h_mode;
            hi_word  <= h_prod[63:32];
            out_data <= beat0_data(h_prod, h_mode, h_flags.ovf);
            out_last <= (h_mode != MODE_BOTH);
            out_ovf  <= h_flags.ovf;
            out_zero <= h_flags.zero;
            out_neg  <= h_flags.neg;
            out_tag  <= h_tag;
        end else if (to_hi) begin
            out_data <= hi_word;
            out_last <= 1'b1;
        end
    end

endmodule
